// File: rtl/contador_bcd_multiplex_pkg.sv
// rtl/contador_bcd_multiplex_pkg.sv - shared BCD width, 7-segment patterns and decoder
package contador_pkg;

    localparam int BCD_W = 4;

    // Active-high {g,f,e,d,c,b,a}; element n is the glyph for digit n
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] nibble);
        if (nibble > 4'd9) return SEG_BLANK;
        return SEG_DIGITS[nibble];
    endfunction

endpackage

// File: rtl/contador_bcd_multiplex_if.sv
// rtl/contador_bcd_multiplex_if.sv - control inputs and count/display outputs of the counter
interface contador_bcd_multiplex_if #(
    parameter int DIGITS = 4
);
    import contador_pkg::*;

    logic                      load_in;
    logic [BCD_W*DIGITS-1:0]   d_in;
    logic                      counter_enable_in;
    logic                      count_up_in;
    logic                      out_enable_in;
    logic [BCD_W*DIGITS-1:0]   bcd_out;
    logic                      terminal_count_out;
    logic [6:0]                sseg_out;
    logic [DIGITS-1:0]         digit_enable;

    modport master (
        output load_in, d_in, counter_enable_in, count_up_in, out_enable_in,
        input  bcd_out, terminal_count_out, sseg_out, digit_enable
    );

    modport slave (
        input  load_in, d_in, counter_enable_in, count_up_in, out_enable_in,
        output bcd_out, terminal_count_out, sseg_out, digit_enable
    );

endinterface

// File: rtl/contador_bcd_multiplex_bcd_decade.sv
// rtl/contador_bcd_multiplex_bcd_decade.sv - one decimal decade with load, up/down and carry/borrow
module bcd_decade
    import contador_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             count_up,
    input  logic [BCD_W-1:0] d,
    input  logic             cin,
    output logic [BCD_W-1:0] q,
    output logic             cout
);

    logic at_limit;

    // cin doubles as the step enable: decade 0 gets the count enable, others the chain
    assign at_limit = count_up ? (q == 4'd9) : (q == 4'd0);
    assign cout     = cin && at_limit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= (d > 4'd9) ? '0 : d;
        end else if (cin) begin
            if (at_limit) q <= count_up ? 4'd0 : 4'd9;
            else          q <= count_up ? q + 4'd1 : q - 4'd1;
        end
    end

endmodule

// File: rtl/contador_bcd_multiplex.sv
// rtl/contador_bcd_multiplex.sv - N-decade BCD up/down counter with multiplexed 7-segment scan
module contador_bcd_multiplex
    import contador_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_LZ   = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    contador_bcd_multiplex_if.slave   bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_INV    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] EN_INV     = {DIGITS{ACTIVE_LOW != 0}};

    logic [DIGITS:0]         carry;
    logic [BCD_W*DIGITS-1:0] bcd;
    logic                    tc_q;
    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [BCD_W-1:0]        sel;
    logic                    lz_blank;
    logic                    all_zero;
    logic [6:0]              seg_n;
    logic [DIGITS-1:0]       en_n;
    logic [6:0]              sseg_q;
    logic [DIGITS-1:0]       en_q;

    assign carry[0] = bus.counter_enable_in;

    for (genvar i = 0; i < DIGITS; i++) begin : g_decade
        bcd_decade u_decade (
            .clk      (clk),
            .rst      (rst),
            .load     (bus.load_in),
            .count_up (bus.count_up_in),
            .d        (bus.d_in[i*BCD_W +: BCD_W]),
            .cin      (carry[i]),
            .q        (bcd[i*BCD_W +: BCD_W]),
            .cout     (carry[i+1])
        );
    end

    // A carry out of the top decade is a full wrap; a load on the same edge overrides it
    always_ff @(posedge clk) begin
        if (!rst) tc_q <= 1'b0;
        else      tc_q <= carry[DIGITS] && !bus.load_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Walk from the top decade down so all_zero covers the selected decade and everything above it
    always_comb begin
        sel      = '0;
        lz_blank = 1'b0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (bcd[i*BCD_W +: BCD_W] == '0);
            if (IW'(i) == idx) begin
                sel      = bcd[i*BCD_W +: BCD_W];
                lz_blank = (i != 0) && all_zero;
            end
        end
    end

    always_comb begin
        seg_n = SEG_BLANK;
        en_n  = '0;
        if (bus.out_enable_in) begin
            seg_n = ((BLANK_LZ != 0) && lz_blank) ? SEG_BLANK : seg_decode(sel);
            for (int i = 0; i < DIGITS; i++) en_n[i] = (IW'(i) == idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sseg_q <= SEG_INV;
            en_q   <= EN_INV;
        end else begin
            sseg_q <= seg_n ^ SEG_INV;
            en_q   <= en_n ^ EN_INV;
        end
    end

    assign bus.bcd_out            = bcd;
    assign bus.terminal_count_out = tc_q;
    assign bus.sseg_out           = sseg_q;
    assign bus.digit_enable       = en_q;

endmodule

// File: tb/tb_contador_bcd_multiplex.sv
// tb/tb_contador_bcd_multiplex.sv - self-checking bench for contador_bcd_multiplex
module tb_contador_bcd_multiplex;

    logic clk;
    logic rst;
    logic load, en, up, oe;
    logic [15:0] d_a;
    logic [23:0] d_b;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    contador_bcd_multiplex_if #(.DIGITS(4)) bus_a ();
    contador_bcd_multiplex_if #(.DIGITS(6)) bus_b ();

    assign bus_a.load_in           = load;
    assign bus_a.d_in              = d_a;
    assign bus_a.counter_enable_in = en;
    assign bus_a.count_up_in       = up;
    assign bus_a.out_enable_in     = oe;
    assign bus_b.load_in           = load;
    assign bus_b.d_in              = d_b;
    assign bus_b.counter_enable_in = en;
    assign bus_b.count_up_in       = up;
    assign bus_b.out_enable_in     = oe;

    contador_bcd_multiplex #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    contador_bcd_multiplex #(.DIGITS(6), .SCAN_DIV(4), .BLANK_LZ(1), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    localparam logic [6:0] SEGS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference: count held as a plain integer modulo 10^DIGITS, scan from edges since reset
    int         ev  [2];
    int         ek  [2];
    bit         etc [2];
    logic [6:0] eseg[2];
    logic [7:0] een [2];

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p *= 10;
        return p;
    endfunction

    function automatic int clamp_load(input logic [31:0] d, input int n);
        int v = 0;
        int nib;
        for (int i = n - 1; i >= 0; i--) begin
            nib = int'(d[i*4 +: 4]);
            if (nib > 9) nib = 0;
            v = v * 10 + nib;
        end
        return v;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int n);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < n; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_edge(input int u);
        int n, m, idx, dig;
        logic [6:0] s;
        logic [7:0] e, emask;
        logic [31:0] d;
        n = (u == 0) ? 4 : 6;
        m = pow10(n);
        emask = 8'((1 << n) - 1);
        d = (u == 0) ? {16'h0, d_a} : {8'h0, d_b};
        s = 7'h00;
        e = 8'h00;
        if (!rst) begin
            ev[u] = 0; ek[u] = 0; etc[u] = 1'b0;
        end else begin
            idx = (ek[u] / 4) % n;
            ek[u]++;
            if (oe) begin
                dig = (ev[u] / pow10(idx)) % 10;
                if (!(idx > 0 && ev[u] < pow10(idx))) s = SEGS[dig];
                e = 8'(1 << idx);
            end
            etc[u] = 1'b0;
            if (load) begin
                ev[u] = clamp_load(d, n);
            end else if (en) begin
                if (up) begin
                    etc[u] = (ev[u] == m - 1);
                    ev[u]  = (ev[u] + 1) % m;
                end else begin
                    etc[u] = (ev[u] == 0);
                    ev[u]  = (ev[u] + m - 1) % m;
                end
            end
        end
        if (u == 0) begin
            eseg[u] = ~s;
            een[u]  = ~e & emask;
        end else begin
            eseg[u] = s;
            een[u]  = e;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("a_bcd",  {16'h0, bus_a.bcd_out},       to_bcd(ev[0], 4));
        chk("a_tc",   {31'h0, bus_a.terminal_count_out}, {31'h0, etc[0]});
        chk("a_seg",  {25'h0, bus_a.sseg_out},      {25'h0, eseg[0]});
        chk("a_en",   {28'h0, bus_a.digit_enable},  {24'h0, een[0]});
        chk("b_bcd",  {8'h0, bus_b.bcd_out},        to_bcd(ev[1], 6));
        chk("b_tc",   {31'h0, bus_b.terminal_count_out}, {31'h0, etc[1]});
        chk("b_seg",  {25'h0, bus_b.sseg_out},      {25'h0, eseg[1]});
        chk("b_en",   {26'h0, bus_b.digit_enable},  {24'h0, een[1]});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_model();
    endtask

    typedef struct {
        bit          rst;
        bit          load;
        bit          en;
        bit          up;
        logic [15:0] d;
        logic [15:0] exp_bcd;
        bit          exp_tc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [3:0] exp_en4;
        logic [6:0] exp_seg;
        bit found;
        int pick;

        vecs.push_back('{1, 1, 0, 1, 16'h9998, 16'h9998, 0});
        vecs.push_back('{1, 0, 1, 1, 16'h0000, 16'h9999, 0});
        vecs.push_back('{1, 0, 1, 1, 16'h0000, 16'h0000, 1});
        vecs.push_back('{1, 0, 0, 1, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1, 1, 0, 0, 16'h1000, 16'h1000, 0});
        vecs.push_back('{1, 0, 1, 0, 16'h0000, 16'h0999, 0});
        vecs.push_back('{1, 1, 0, 0, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1, 0, 1, 0, 16'h0000, 16'h9999, 1});
        vecs.push_back('{1, 1, 1, 1, 16'hA5C3, 16'h0503, 0});
        vecs.push_back('{0, 1, 0, 1, 16'h1234, 16'h0000, 0});
        vecs.push_back('{1, 1, 0, 1, 16'h0042, 16'h0042, 0});

        rst = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; oe = 1'b1;
        d_a = '0; d_b = '0;

        // Reset state, then one full scan of the blanked zero count
        repeat (3) tick();
        chk("rst_bcd", {16'h0, bus_a.bcd_out}, 32'h0);
        chk("rst_en",  {28'h0, bus_a.digit_enable}, 32'hF);
        chk("rst_seg", {25'h0, bus_a.sseg_out}, 32'h7F);
        chk("rst_tc",  {31'h0, bus_a.terminal_count_out}, 32'h0);
        rst = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                exp_en4 = 4'hF;
                exp_en4[s] = 1'b0;
                exp_seg = (s == 0) ? 7'b1000000 : 7'h7F;
                chk("scan_en",  {28'h0, bus_a.digit_enable}, {28'h0, exp_en4});
                chk("scan_seg", {25'h0, bus_a.sseg_out}, {25'h0, exp_seg});
            end
        end

        // Directed count vectors
        foreach (vecs[i]) begin
            rst = vecs[i].rst; load = vecs[i].load; en = vecs[i].en; up = vecs[i].up;
            d_a = vecs[i].d;
            tick();
            chk("vec_bcd", {16'h0, bus_a.bcd_out}, {16'h0, vecs[i].exp_bcd});
            chk("vec_tc",  {31'h0, bus_a.terminal_count_out}, {31'h0, vecs[i].exp_tc});
        end
        rst = 1'b1; load = 1'b0; en = 1'b0;

        // Leading-zero blanking of 0042
        for (int i = 0; i < 16; i++) begin
            tick();
            case (een[0][3:0])
                4'b1110: exp_seg = 7'b0100100;
                4'b1101: exp_seg = 7'b0011001;
                default: exp_seg = 7'h7F;
            endcase
            chk("blank_seg", {25'h0, bus_a.sseg_out}, {25'h0, exp_seg});
        end

        oe = 1'b0;
        tick();
        chk("oe_en",  {28'h0, bus_a.digit_enable}, 32'hF);
        chk("oe_seg", {25'h0, bus_a.sseg_out}, 32'h7F);
        repeat (2) tick();
        oe = 1'b1;
        repeat (3) tick();

        // Active-high six-digit instance showing 123456
        d_b = 24'h123456;
        load = 1'b1;
        tick();
        load = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus_b.digit_enable == 6'b000001) found = 1'b1;
        end
        chk("pol_found", {31'h0, found}, 32'h1);
        if (found) chk("pol_seg", {25'h0, bus_b.sseg_out}, {25'h0, 7'b1111101});

        // Randomised traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 63) != 0);
            load = ($urandom_range(0, 7) == 0);
            en   = $urandom_range(0, 1);
            up   = $urandom_range(0, 1);
            oe   = ($urandom_range(0, 15) != 0);
            pick = $urandom_range(0, 3);
            case (pick)
                0:       begin d_a = 16'h9999; d_b = 24'h999999; end
                1:       begin d_a = 16'h0000; d_b = 24'h000000; end
                2:       begin d_a = 16'h9990; d_b = 24'h000009; end
                default: begin d_a = 16'($urandom); d_b = 24'($urandom); end
            endcase
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
